// File: rtl/mem_ram_be.sv
// rtl/mem_ram_be.sv - single-port byte-enable RAM with registered read pipeline and clear sweep
module mem_ram_be #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int DEPTH          = 16,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cs,
  input  logic                    we,
  input  logic                    oe,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic                    clear,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_valid,
  output logic                    busy,
  output logic                    err
);

  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  localparam state_e                RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W     = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);

  // Illegal parameter combinations stop elaboration rather than build a broken RAM.
  generate
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
      $error("mem_ram_be: DATA_WIDTH must be a positive multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("mem_ram_be: DEPTH must be in 1..2**ADDR_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
      $error("mem_ram_be: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  // Storage array; deliberately not reset, the clear sweep zeroes it.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rd_data1_q, rd_data1_d;
  logic                  rd_vld1_q, rd_vld1_d;
  logic                  err_q, err_d;

  logic                  req_acc;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign busy = (state_q == S_CLEAR);

  // Request decode: a clear in the same cycle wins and drops the request.
  always_comb begin
    req_acc   = cs & (we | oe) & ~busy & ~clear;
    in_range  = ({1'b0, addr} < DEPTH_W);
    rd_idx    = in_range ? addr : '0;
    cur_word  = mem_q[rd_idx];
    lane_mask = '0;
    for (int i = 0; i < NB; i++) begin
      lane_mask[8*i +: 8] = {8{be[i] & we}};
    end
    // Write-first: a same-cycle read sees the old word with new enabled lanes.
    merged_word = (cur_word & ~lane_mask) | (data & lane_mask);
    rd_word     = in_range ? merged_word : '0;
  end

  // Array write port, shared between the sweep (zero fill) and accepted writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = merged_word;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (req_acc && we && in_range && (|be)) begin
      mem_we    = 1'b1;
    end
  end

  // Array storage update.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Clear sequencer next state: sweep one word per cycle, then return to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // First read stage and error strobe; read data holds between reads.
  always_comb begin
    rd_vld1_d  = req_acc & oe;
    rd_data1_d = rd_vld1_d ? rd_word : rd_data1_q;
    err_d      = req_acc & ~in_range;
  end

  // First read stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld1_q  <= 1'b0;
      rd_data1_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_vld1_q  <= rd_vld1_d;
      rd_data1_q <= rd_data1_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] rd_data2_q, rd_data2_d;
      logic                  rd_vld2_q, rd_vld2_d;

      // Second read stage: forward stage one only when it carries a read.
      always_comb begin
        rd_vld2_d  = rd_vld1_q;
        rd_data2_d = rd_vld1_q ? rd_data1_q : rd_data2_q;
      end

      // Second read stage registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_vld2_q  <= 1'b0;
          rd_data2_q <= '0;
        end else begin
          rd_vld2_q  <= rd_vld2_d;
          rd_data2_q <= rd_data2_d;
        end
      end

      assign read_valid = rd_vld2_q;
      assign read_data  = rd_data2_q;
    end else begin : g_lat1
      assign read_valid = rd_vld1_q;
      assign read_data  = rd_data1_q;
    end
  endgenerate

endmodule

// File: tb/tb_mem_ram_be.sv
// tb/tb_mem_ram_be.sv - directed self-checking bench for mem_ram_be
module tb_mem_ram_be;

  logic        clk;
  logic        rst_n;

  // Instance a: DEPTH 16, READ_LATENCY 1
  logic        a_cs, a_we, a_oe, a_clear;
  logic [3:0]  a_addr;
  logic [15:0] a_data;
  logic [1:0]  a_be;
  logic [15:0] a_read_data;
  logic        a_read_valid, a_busy, a_err;

  // Instance b: DEPTH 12, READ_LATENCY 2
  logic        b_cs, b_we, b_oe, b_clear;
  logic [3:0]  b_addr;
  logic [15:0] b_data;
  logic [1:0]  b_be;
  logic [15:0] b_read_data;
  logic        b_read_valid, b_busy, b_err;

  int passed;
  int total;

  int  na, nb;
  bit  saw;

  mem_ram_be #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(16), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .cs(a_cs), .we(a_we), .oe(a_oe), .addr(a_addr),
    .data(a_data), .be(a_be), .clear(a_clear), .read_data(a_read_data),
    .read_valid(a_read_valid), .busy(a_busy), .err(a_err)
  );

  mem_ram_be #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(12), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .cs(b_cs), .we(b_we), .oe(b_oe), .addr(b_addr),
    .data(b_data), .be(b_be), .clear(b_clear), .read_data(b_read_data),
    .read_valid(b_read_valid), .busy(b_busy), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic a_idle();
    a_cs = 0; a_we = 0; a_oe = 0; a_clear = 0; a_addr = '0; a_data = '0; a_be = '0;
  endtask

  task automatic b_idle();
    b_cs = 0; b_we = 0; b_oe = 0; b_clear = 0; b_addr = '0; b_data = '0; b_be = '0;
  endtask

  task automatic a_wr(input logic [3:0] ad, input logic [15:0] d, input logic [1:0] bev);
    @(negedge clk);
    a_cs = 1; a_we = 1; a_addr = ad; a_data = d; a_be = bev;
    @(negedge clk);
    a_idle();
  endtask

  task automatic a_rd(input string tag, input logic [3:0] ad, input logic [15:0] exp);
    @(negedge clk);
    a_cs = 1; a_oe = 1; a_addr = ad;
    @(negedge clk);
    a_idle();
    check({tag, "_valid"}, a_read_valid, 1);
    check({tag, "_data"}, a_read_data, exp);
  endtask

  task automatic b_wr(input logic [3:0] ad, input logic [15:0] d, input logic [1:0] bev);
    @(negedge clk);
    b_cs = 1; b_we = 1; b_addr = ad; b_data = d; b_be = bev;
    @(negedge clk);
    b_idle();
  endtask

  task automatic b_rd(input string tag, input logic [3:0] ad, input logic [15:0] exp);
    @(negedge clk);
    b_cs = 1; b_oe = 1; b_addr = ad;
    @(negedge clk);
    b_idle();
    check({tag, "_early"}, b_read_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, b_read_valid, 1);
    check({tag, "_data"}, b_read_data, exp);
  endtask

  // Called right after rst_n rises; counts cycles each instance stays busy.
  task automatic count_sweep(output int ca, output int cb, output bit sv);
    ca = 0; cb = 0; sv = 0;
    for (int i = 0; i < 100; i++) begin
      if (!a_busy && !b_busy) break;
      if (a_busy) ca++;
      if (b_busy) cb++;
      if (a_read_valid || b_read_valid) sv = 1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 0;
    a_idle();
    b_idle();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", a_busy, 1);
    check("rst_valid", a_read_valid, 0);
    check("rst_data", a_read_data, 0);
    check("rst_err", a_err, 0);
    check("rst_b_busy", b_busy, 1);

    // 1: sweep after reset release, then everything reads zero
    rst_n = 1;
    count_sweep(na, nb, saw);
    check("t1_busy_cycles", na, 16);
    check("t1_b_busy_cycles", nb, 12);
    for (int i = 0; i < 16; i++) a_rd($sformatf("t1_rd%0d", i), 4'(i), 16'h0000);

    // 2: partial byte write
    a_wr(4'd3, 16'hA5C3, 2'b11);
    a_wr(4'd3, 16'h1200, 2'b10);
    a_rd("t2_rd3", 4'd3, 16'h12C3);

    // 3: write-first same-cycle read
    a_wr(4'd5, 16'hFFFF, 2'b11);
    @(negedge clk);
    a_cs = 1; a_we = 1; a_oe = 1; a_addr = 4'd5; a_data = 16'h0011; a_be = 2'b01;
    @(negedge clk);
    a_idle();
    check("t3_wf_valid", a_read_valid, 1);
    check("t3_wf_data", a_read_data, 16'hFF11);
    a_rd("t3_rd5", 4'd5, 16'hFF11);

    // 4: back-to-back reads at latency 2
    for (int i = 0; i < 4; i++) b_wr(4'(i), 16'(16'h1000 + i), 2'b11);
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      check($sformatf("t4_valid_c%0d", j), b_read_valid, (j >= 2 && j <= 5) ? 1 : 0);
      if (j >= 2 && j <= 5) check($sformatf("t4_data_c%0d", j), b_read_data, 16'h1000 + j - 2);
      if (j < 4) begin
        b_cs = 1; b_oe = 1; b_addr = 4'(j);
      end else begin
        b_idle();
      end
    end

    // 5: out-of-range write and read with DEPTH 12
    @(negedge clk);
    b_cs = 1; b_we = 1; b_addr = 4'd13; b_data = 16'hBEEF; b_be = 2'b11;
    @(negedge clk);
    b_idle();
    check("t5_wr_err", b_err, 1);
    @(negedge clk);
    check("t5_wr_err_clr", b_err, 0);
    b_cs = 1; b_oe = 1; b_addr = 4'd13;
    @(negedge clk);
    b_idle();
    check("t5_rd_err", b_err, 1);
    check("t5_rd_early", b_read_valid, 0);
    @(negedge clk);
    check("t5_rd_err_clr", b_err, 0);
    check("t5_rd_valid", b_read_valid, 1);
    check("t5_rd_data", b_read_data, 16'h0000);
    for (int i = 0; i < 12; i++)
      b_rd($sformatf("t5_keep%0d", i), 4'(i), (i < 4) ? 16'(16'h1000 + i) : 16'h0000);

    // 6: in-flight read survives clear, dropped read, reset mid-sweep
    @(negedge clk);
    a_cs = 1; a_oe = 1; a_addr = 4'd5;
    @(negedge clk);
    a_idle();
    a_clear = 1;
    check("t6_inflight_valid", a_read_valid, 1);
    check("t6_inflight_data", a_read_data, 16'hFF11);
    @(negedge clk);
    a_clear = 0;
    check("t6_busy", a_busy, 1);
    a_cs = 1; a_oe = 1; a_we = 1; a_addr = 4'd13; a_data = 16'h5555; a_be = 2'b11;
    @(negedge clk);
    a_idle();
    check("t6_drop_valid", a_read_valid, 0);
    check("t6_drop_err", a_err, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("t6_rst_data", a_read_data, 0);
    check("t6_rst_valid", a_read_valid, 0);
    check("t6_rst_err", a_err, 0);
    check("t6_rst_busy", a_busy, 1);
    check("t6_rst_b_data", b_read_data, 0);
    @(negedge clk);
    rst_n = 1;
    count_sweep(na, nb, saw);
    check("t6_busy_cycles", na, 16);
    check("t6_b_busy_cycles", nb, 12);
    check("t6_no_valid", saw, 0);
    a_rd("t6_rd3", 4'd3, 16'h0000);
    a_rd("t6_rd5", 4'd5, 16'h0000);
    a_rd("t6_rd13", 4'd13, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_ram_be.md
# mem_ram_be

Parametrised single-port synchronous RAM with per-byte write enables, a configurable registered read pipeline, and a hardware clear sequencer. It replaces the earlier fixed 16×16 memory in the datapath. All activity moves to the rising edge. A `read_valid` strobe qualifies returned data. Contents are zeroed after reset or on command, without relying on a reset of the storage array.

## Interface
- `ADDR_WIDTH`, 4, address bits.
- `DATA_WIDTH`, 16, word width; must be a multiple of 8.
- `DEPTH`, 16, number of words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- `READ_LATENCY`, 1, read pipeline depth; legal values 1 or 2.
- `CLEAR_ON_RESET`, 1, when 1 a clear sweep starts automatically on reset release.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cs`  in  1  chip select; qualifies `we` and `oe`.
- `we`  in  1  write request.
- `oe`  in  1  read request.
- `addr`  in  ADDR_WIDTH  word address.
- `data`  in  DATA_WIDTH  write data.
- `be`  in  DATA_WIDTH/8  byte enables; bit i covers `data[8i+7:8i]`.
- `clear`  in  1  single-cycle request to zero the whole array.
- `read_data`  out  DATA_WIDTH  read result; holds its value between reads.
- `read_valid`  out  1  one-cycle strobe; `read_data` is valid in that cycle.
- `busy`  out  1  clear sweep in progress; requests are not accepted.
- `err`  out  1  one-cycle strobe for an accepted request with `addr` ≥ DEPTH.

## Operation
- Accepted request: `cs` & (`we` | `oe`) & !`busy`. Requests presented while `busy` is high are dropped: no write, no `read_valid`, no `err`.
- Write: each byte lane with `be[i]`=1 is updated from `data`. Lanes with `be[i]`=0 keep their old value. `be`=0 performs no write.
- Read: the word at `addr` enters the read pipeline.
- Simultaneous `we` & `oe`: write-first. The read returns the old word merged with the newly written enabled bytes.
- Out-of-range `addr` (≥ DEPTH): the write is suppressed. A read returns all zeros and still raises `read_valid`. `err` pulses in the cycle after the request.
- Clear FSM states:
  - IDLE → CLEAR on `clear`=1 while not busy.
  - CLEAR writes zero to the word at the sweep counter, starting at 0 and advancing by 1 each cycle.
  - CLEAR → IDLE after writing address DEPTH-1; the counter resets to 0.
  - `busy` = (state == CLEAR).
- `clear` asserted while already busy is ignored; the sweep is not restarted.
- `clear` arriving in the same cycle as a request takes priority. The request is dropped and has no effect.
- Reset (`rst_n` low), asynchronous:
  - state = CLEAR if CLEAR_ON_RESET=1, otherwise IDLE; sweep counter = 0.
  - read pipeline flushed.
  - `read_data`=0, `read_valid`=0, `err`=0, `busy`=CLEAR_ON_RESET.
  - The storage array is not reset; array contents are undefined until a sweep completes.
- Reset asserted mid-sweep aborts the sweep. With CLEAR_ON_RESET=1 it restarts from address 0 on release.
- Reset asserted with reads in flight: those reads never produce `read_valid`.

## Timing
- Cycle numbering: a request present in cycle c is sampled at the rising edge that ends cycle c.
- Read latency: `read_valid`=1 and `read_data` valid in cycle c+READ_LATENCY.
- Back-to-back reads, one per cycle, give `read_valid` on consecutive cycles (full throughput).
- A write in cycle c is visible to a read issued in cycle c+1 or later, and to a same-cycle read through write-first merging.
- `err` is high in cycle c+1 only.
- Sweep started by `clear` in cycle c:
  - `busy` is high in cycles c+1 … c+DEPTH and low in cycle c+DEPTH+1.
  - The first request that can be accepted is in cycle c+DEPTH+1.
- Sweep after reset release (CLEAR_ON_RESET=1): `busy` stays high for DEPTH rising edges after release.
- Reads already in the pipeline when `clear` arrives still complete. They return data sampled before any clear write.

## Test plan
1. Reset release, CLEAR_ON_RESET=1, DEPTH=16 → `busy` high for exactly 16 cycles. Afterwards, reading addresses 0–15 returns 0x0000 each, with `read_valid` at latency L.
2. Write 0xA5C3 to address 3 with `be`=2'b11, then write 0x1200 with `be`=2'b10 → reading address 3 returns 0x12C3.
3. Same cycle: `we`=`oe`=1, `addr`=5, old word 0xFFFF, `data`=0x0011, `be`=2'b01 → returns 0xFF11; a later read also returns 0xFF11.
4. Four back-to-back reads, addresses 0–3, with READ_LATENCY=2 → `read_valid` high for 4 consecutive cycles starting 2 cycles after the first request, data in order.
5. DEPTH=12, ADDR_WIDTH=4; write 0xBEEF to address 13, then read address 13 → `err` pulses once after each request; the read returns 0x0000; addresses 0–11 are unchanged.
6. `clear` pulse, then `rst_n` low for 1 cycle in sweep cycle 5, with a read request during the sweep → the sweep restarts from 0 and `busy` stays high for 16 full cycles after release. The dropped read produces no `read_valid`; all outputs are 0 during reset.
